// File: rtl/hwt_pkg.sv
// Shared definitions for the hwt self-test checker.
// Optional feature macro: HWT_CHK_SYNC_EN (see hwt_checker.sv).
package hwt_pkg;

    // Width of the hwt input vector {D,C,B,A}
    localparam int VEC_W = 4;

    // Width of the mismatch counter; holds 0..16 without overflow
    localparam int ERR_W = 5;

    // Expected hwt output per vector index: Y = D & (C ^ (A & B))
    localparam logic [15:0] HWT_GOLDEN = 16'h7800;

    // Checker sequencing states
    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        FINISH
    } state_t;

    // Number of cycles a vector sits in APPLY before it is sampled
    function automatic int apply_cycles(input int settle, input bit sync_en);
        if (sync_en)
            return settle + 2;
        else
            return (settle < 1) ? 1 : settle;
    endfunction

endpackage

// File: rtl/hwt_sync2.sv
// Two-flop synchronizer for the hwt Y readback.
// Only built when HWT_CHK_SYNC_EN is defined; the default checker
// compares y_i directly and has no use for this module.
`ifdef HWT_CHK_SYNC_EN
module hwt_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make meta->q a real two-stage
            // pipeline; blocking ones would collapse it into a single flop.
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`endif

// File: rtl/hwt_checker.sv
// Self-test initiator for the 4-input hwt cell: sweeps all 16 input
// vectors, compares Y against a golden table and reports pass/fail,
// the mismatch count and the first failing vector.
// Optional feature macro: HWT_CHK_SYNC_EN -- when defined, y_i passes
// through a 2-flop synchronizer and each vector is held 2 cycles longer.
module hwt_checker
    import hwt_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 2,          // 0..15
    parameter logic [15:0] GOLDEN        = HWT_GOLDEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    output logic             d_o,
    input  logic             y_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [VEC_W-1:0] fail_vec
);

`ifdef HWT_CHK_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    // Last value of the wait counter before APPLY hands over to SAMPLE
    localparam int         APPLY_CYC  = apply_cycles(SETTLE_CYCLES, SYNC_EN);
    localparam logic [4:0] APPLY_LAST = 5'(APPLY_CYC - 1);

    state_t             state;
    logic [VEC_W-1:0]   vec;
    logic [VEC_W-1:0]   drive;
    logic [4:0]         wait_cnt;
    logic               pass_r;
    logic               done_seen;
    logic               y_cmp;
    logic               mismatch;
    logic [ERR_W-1:0]   err_next;

`ifdef HWT_CHK_SYNC_EN
    logic y_sync;

    hwt_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (y_i),
        .q     (y_sync)
    );

    assign y_cmp = y_sync;
`else
    assign y_cmp = y_i;
`endif

    // Mismatch detect and the error count as it will stand after this SAMPLE
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        mismatch = 1'b0;
        err_next = err_count;
        if (state == SAMPLE) begin
            mismatch = (y_cmp != GOLDEN[vec]);
            err_next = err_count + ERR_W'(mismatch);
        end
    end

    // Sweep sequencer with registered drive, status and result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            drive      <= '0;
            wait_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass_r     <= 1'b0;
            done_seen  <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= APPLY;
                        vec        <= '0;
                        drive      <= '0;
                        wait_cnt   <= '0;
                        busy       <= 1'b1;
                        pass_r     <= 1'b0;
                        done_seen  <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_vec   <= '0;
                    end
                end

                APPLY: begin
                    if (wait_cnt == APPLY_LAST) begin
                        state    <= SAMPLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 5'd1;
                    end
                end

                SAMPLE: begin
                    err_count <= err_next;
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= vec;
                    end
                    if (vec == {VEC_W{1'b1}}) begin
                        // Last vector: report and release the cell inputs
                        state     <= FINISH;
                        drive     <= '0;
                        done      <= 1'b1;
                        done_seen <= 1'b1;
                        pass_r    <= (err_next == '0);
                    end else begin
                        state <= APPLY;
                        vec   <= vec + 1'b1;
                        drive <= vec + 1'b1;
                    end
                end

                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    drive <= '0;
                end
            endcase
        end
    end

    assign {d_o, c_o, b_o, a_o} = drive;

    // The pass flag only means something once a sweep has reported
    assign pass = pass_r & done_seen;

endmodule

// File: tb/tb_hwt_checker.sv
// Self-checking bench for hwt_checker: models the hwt cell (with
// selectable faults) and scores each sweep against a predicted result.
module tb_hwt_checker;

    localparam logic [15:0] TB_GOLDEN = 16'h7800;
`ifdef HWT_CHK_SYNC_EN
    localparam int PER_VEC = 5;
`else
    localparam int PER_VEC = 3;
`endif
    localparam int PER_SWEEP = 16 * PER_VEC;

    // Cell behaviour modes
    localparam int M_GOOD   = 0;
    localparam int M_STUCK0 = 1;
    localparam int M_STUCK1 = 2;
    localparam int M_INVERT = 3;

    typedef struct {
        logic       pass;
        logic [4:0] err;
        logic       fv;
        logic [3:0] fvec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       a_o, b_o, c_o, d_o;
    logic       y_i;
    logic       busy, done, pass, fail_valid;
    logic [4:0] err_count;
    logic [3:0] fail_vec;
    int         mode = M_GOOD;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    hwt_checker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_o        (a_o),
        .b_o        (b_o),
        .c_o        (c_o),
        .d_o        (d_o),
        .y_i        (y_i),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_vec   (fail_vec)
    );

    always #5 clk = ~clk;

    function automatic logic model_y(input logic [3:0] v, input int m);
        logic y;
        y = v[3] & (v[2] ^ (v[1] & v[0]));
        case (m)
            M_STUCK0: return 1'b0;
            M_STUCK1: return 1'b1;
            M_INVERT: return ~y;
            default:  return y;
        endcase
    endfunction

    assign y_i = model_y({d_o, c_o, b_o, a_o}, mode);

    function automatic exp_t predict(input int m);
        exp_t        e;
        logic [15:0] g;
        g      = TB_GOLDEN;
        e.err  = '0;
        e.fv   = 1'b0;
        e.fvec = '0;
        for (int i = 0; i < 16; i++) begin
            if (model_y(4'(i), m) !== g[i]) begin
                if (!e.fv) begin
                    e.fv   = 1'b1;
                    e.fvec = 4'(i);
                end
                e.err = e.err + 5'd1;
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full sweep; extra_k >= 0 pulses start again k cycles into it
    task automatic run_sweep(input int m, input int extra_k);
        exp_t e;
        int   k;
        int   trace_err;
        int   stray;
        bit   got;
        mode = m;
        sb.push_back(predict(m));
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        trace_err = 0;
        got = 1'b0;
        while (k < 4 * PER_SWEEP && !got) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (k < PER_SWEEP &&
                    ({d_o, c_o, b_o, a_o} !== 4'(k / PER_VEC) || busy !== 1'b1))
                    trace_err++;
                start = (k == extra_k);
                @(posedge clk);
                #1 k++;
            end
        end
        start = 1'b0;
        check($sformatf("m%0d done_seen", m), 32'(got), 32'd1);
        check($sformatf("m%0d done_latency", m), k, PER_SWEEP);
        check($sformatf("m%0d drive_trace", m), trace_err, 0);
        check($sformatf("m%0d drive_at_done", m), {d_o, c_o, b_o, a_o}, 4'h0);
        e = sb.pop_front();
        check($sformatf("m%0d pass", m), pass, e.pass);
        check($sformatf("m%0d err_count", m), err_count, e.err);
        check($sformatf("m%0d fail_valid", m), fail_valid, e.fv);
        check($sformatf("m%0d fail_vec", m), fail_vec, e.fvec);
        // done must be a single pulse and results must hold afterwards
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        check($sformatf("m%0d idle_after", m), stray, 0);
        check($sformatf("m%0d err_hold", m), err_count, e.err);
        check($sformatf("m%0d pass_hold", m), pass, e.pass);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " done"}, done, 1'b0);
        check({tag, " pass"}, pass, 1'b0);
        check({tag, " err_count"}, err_count, 5'd0);
        check({tag, " fail_valid"}, fail_valid, 1'b0);
        check({tag, " fail_vec"}, fail_vec, 4'd0);
        check({tag, " drive"}, {d_o, c_o, b_o, a_o}, 4'h0);
    endtask

    initial begin
        int k;
        int seen_done;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_idle_zero("reset");
        rst_n = 1'b1;

        // Fault-free cell with a second start while busy
        run_sweep(M_GOOD, 10);
        // Faulty cells
        run_sweep(M_STUCK0, -1);
        run_sweep(M_STUCK1, -1);
        run_sweep(M_INVERT, -1);

        // Reset mid-sweep while vector 5 is driven (faulty cell so the
        // counters are non-zero when reset hits)
        mode = M_INVERT;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        while (k < 4 * PER_SWEEP && {d_o, c_o, b_o, a_o} !== 4'd5) begin
            @(posedge clk);
            #1 k++;
        end
        check("abort reached_vec5", {d_o, c_o, b_o, a_o}, 4'd5);
        rst_n = 1'b0;
        @(posedge clk);
        #1 check_idle_zero("abort");
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < PER_SWEEP + 10; i++) begin
            @(posedge clk);
            #1 if (done !== 1'b0 || busy !== 1'b0) seen_done++;
        end
        check("abort no_done", seen_done, 0);

        // A fresh sweep after the abort runs normally
        run_sweep(M_GOOD, -1);

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
